// File: rtl/frame_tx.sv
// frame_tx: serialises a 20-bit word as an inverted, oversampled line frame (start, data, parity, stop) plus idle gap.
// Optional parity-error injection port is built in only when FRAME_TX_PAR_INJ_EN is defined.
module frame_tx #(
    parameter int BIT_CLKS = 4,
    parameter int GAP_CLKS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        txd,
    output logic        busy,
    output logic        done
`ifdef FRAME_TX_PAR_INJ_EN
    ,
    input  logic        inj_par_err
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    localparam int SLOT_W = $clog2(BIT_CLKS);
    localparam int GAP_W  = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BIT_CLKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CLKS - 1);

    logic [2:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [4:0]        bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [19:0]       shift_q, shift_d;
    logic              par_q, par_d;
    logic              short_q, short_d;
    logic              txd_q, txd_d;
    logic              done_q, done_d;
    logic              slot_end;
    logic [SLOT_W-1:0] slot_nxt;
    logic              par_in;

    assign slot_end = (slot_q == SLOT_LAST);
    assign slot_nxt = slot_end ? '0 : slot_q + SLOT_W'(1);

`ifdef FRAME_TX_PAR_INJ_EN
    assign par_in = (^tx_data) ^ inj_par_err;
`else
    assign par_in = ^tx_data;
`endif

    // txd is computed from the current state, so the line lags the state register by one clock.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        par_d   = par_q;
        short_d = short_q;
        txd_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    par_d   = par_in;
                    short_d = (tx_data[19:16] == 4'b1100) || (tx_data[19:16] == 4'b1000);
                    slot_d  = '0;
                    bit_d   = 5'd0;
                    gap_d   = '0;
                end
            end
            S_START: begin
                txd_d  = 1'b1;
                slot_d = slot_nxt;
                if (slot_end) begin
                    state_d = S_DATA;
                    bit_d   = 5'd1;
                end
            end
            S_DATA: begin
                txd_d  = ~shift_q[19];
                slot_d = slot_nxt;
                if (slot_end) begin
                    shift_d = {shift_q[18:0], 1'b0};
                    if (short_q && bit_q == 5'd4) begin
                        state_d = S_GAP;
                        done_d  = 1'b1;
                    end else if (bit_q == 5'd20) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                txd_d  = par_q;
                slot_d = slot_nxt;
                if (slot_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                slot_d = slot_nxt;
                if (slot_end) begin
                    state_d = S_GAP;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    gap_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            bit_q   <= 5'd0;
            gap_q   <= '0;
            shift_q <= 20'd0;
            par_q   <= 1'b0;
            short_q <= 1'b0;
            txd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            short_q <= short_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = ~tx_ready;
    assign txd      = txd_q;
    assign done     = done_q;

endmodule

// File: tb/tb_frame_tx.sv
// Self-checking bench for frame_tx: random and directed frames compared cycle by cycle against a line-level model.
// Parity injection is exercised only when FRAME_TX_PAR_INJ_EN is defined.
module tb_frame_tx;

   localparam int BIT_CLKS = 4;
   localparam int GAP_CLKS = 64;
`ifdef FRAME_TX_PAR_INJ_EN
   localparam bit INJ_EN = 1'b1;
`else
   localparam bit INJ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [19:0] tx_data = 20'd0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic        txd;
   logic        busy;
   logic        done;
`ifdef FRAME_TX_PAR_INJ_EN
   logic        inj_par_err = 1'b0;
`endif

   int passCount = 0;
   int failCount = 0;
   int checkCount = 0;
   bit expLine[$];

   frame_tx #(
      .BIT_CLKS(BIT_CLKS),
      .GAP_CLKS(GAP_CLKS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .txd(txd),
      .busy(busy),
      .done(done)
`ifdef FRAME_TX_PAR_INJ_EN
      ,
      .inj_par_err(inj_par_err)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Watchdog so the run always terminates even if the design stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point shared by all directed steps.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Line model: one entry per bit slot, built directly from the frame format.
   task automatic buildLine(input logic [19:0] d, input bit inj);
      bit isShort;
      int nData;
      expLine.delete();
      isShort = (d[19:16] == 4'hC) || (d[19:16] == 4'h8);
      nData = isShort ? 4 : 20;
      expLine.push_back(1'b1);
      for (int i = 0; i < nData; i++) expLine.push_back(~d[19 - i]);
      if (!isShort) begin
         expLine.push_back((^d) ^ (inj & INJ_EN));
         expLine.push_back(1'b0);
      end
   endtask

   // Drive one word once the block is ready; optionally keep tx_valid asserted afterwards.
   task automatic applyStimulus(input logic [19:0] d, input bit inj, input bit hold);
      for (int i = 0; i < 300 && !tx_ready; i++) @(negedge clk);
      checkOutput("ready_wait", tx_ready, 1);
      tx_data  = d;
      tx_valid = 1'b1;
`ifdef FRAME_TX_PAR_INJ_EN
      inj_par_err = inj;
`endif
      @(posedge clk);
      #1;
      checkOutput("accepted", tx_ready, 0);
      if (!hold) tx_valid = 1'b0;
      tx_data = 20'($urandom);
`ifdef FRAME_TX_PAR_INJ_EN
      inj_par_err = 1'($urandom);
`endif
   endtask

   // Called 1 time unit after the accept edge; walks the whole frame and gap.
   task automatic checkFrame(input logic [19:0] d, input bit inj);
      int len;
      buildLine(d, inj);
      len = expLine.size() * BIT_CLKS;
      for (int k = 1; k <= len; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("txd[%0d]", k), txd, expLine[(k - 1) / BIT_CLKS]);
         checkOutput($sformatf("done[%0d]", k), done, (k == len));
         checkOutput($sformatf("busy[%0d]", k), busy, 1);
      end
      for (int k = 1; k <= GAP_CLKS; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("gap_txd[%0d]", k), txd, 0);
         checkOutput($sformatf("gap_done[%0d]", k), done, 0);
         checkOutput($sformatf("gap_ready[%0d]", k), tx_ready, (k == GAP_CLKS));
      end
   endtask

   initial begin
      logic [19:0] w;
      logic [19:0] w2;

      #1;
      checkOutput("rst_txd", txd, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_ready", tx_ready, 1);
      checkOutput("rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed frames");
      applyStimulus(20'h5A5A5, 1'b0, 1'b0);
      checkFrame(20'h5A5A5, 1'b0);
      applyStimulus(20'hC1234, 1'b0, 1'b0);
      checkFrame(20'hC1234, 1'b0);
      applyStimulus(20'h00001, 1'b0, 1'b0);
      checkFrame(20'h00001, 1'b0);
      applyStimulus(20'h81234, 1'b0, 1'b0);
      checkFrame(20'h81234, 1'b0);

`ifdef FRAME_TX_PAR_INJ_EN
      $display("[TB] parity injection");
      applyStimulus(20'h5A5A5, 1'b1, 1'b0);
      checkFrame(20'h5A5A5, 1'b1);
      applyStimulus(20'hC5A5A, 1'b1, 1'b0);
      checkFrame(20'hC5A5A, 1'b1);
`endif

      $display("[TB] random frames");
      for (int n = 0; n < 6; n++) begin
         w = 20'($urandom);
         if ($urandom_range(0, 2) == 0) w[19:16] = ($urandom_range(0, 1) == 1) ? 4'hC : 4'h8;
         applyStimulus(w, 1'b0, 1'b0);
         checkFrame(w, 1'b0);
      end

      $display("[TB] back-to-back");
      w  = 20'($urandom);
      w2 = 20'($urandom);
      applyStimulus(w, 1'b0, 1'b1);
      tx_data = w2;
`ifdef FRAME_TX_PAR_INJ_EN
      inj_par_err = 1'b0;
`endif
      checkFrame(w, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("b2b_accept", tx_ready, 0);
      tx_valid = 1'b0;
      tx_data  = 20'($urandom);
      checkFrame(w2, 1'b0);

      $display("[TB] reset mid-frame");
      applyStimulus(20'h00000, 1'b0, 1'b0);
      repeat (42) @(posedge clk);
      #1;
      checkOutput("pre_rst_txd", txd, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_txd", txd, 0);
      checkOutput("mid_rst_ready", tx_ready, 1);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_done", done, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("post_rst_ready[%0d]", k), tx_ready, 1);
         checkOutput($sformatf("post_rst_done[%0d]", k), done, 0);
         checkOutput($sformatf("post_rst_txd[%0d]", k), txd, 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
